// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two writeback ports,
// per-register busy scoreboard and optional same-cycle write bypass.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wa_en,
  input  logic [ADDR_W-1:0]          wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              wa_eff;
  logic              wb_eff;
  logic              rsv_eff;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // rst masks every same-cycle update, including bypass
  assign wa_eff  = !rst && wa_en && !is_zero(wa_addr);
  assign wb_eff  = !rst && wb_en && !is_zero(wb_addr);
  assign rsv_eff = !rst && rsv_en && !is_zero(rsv_addr);

  // reserve applied last: a new producer supersedes the write
  always_comb begin
    busy_nxt = busy;
    if (wa_eff)
      busy_nxt[wa_addr] = 1'b0;
    if (wb_eff)
      busy_nxt[wb_addr] = 1'b0;
    if (rsv_eff)
      busy_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wa_eff)
        regs[wa_addr] <= wa_data;
      // port B issued last so it wins a shared address
      if (wb_eff)
        regs[wb_addr] <= wb_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = regs[a];
      b = busy[a];
      if (is_zero(a)) begin
        d = '0;
        b = 1'b0;
      end else if ((BYPASS != 0) && wb_eff && (wb_addr == a)) begin
        d = wb_data;
        b = rsv_eff && (rsv_addr == a);
      end else if ((BYPASS != 0) && wa_eff && (wa_addr == a)) begin
        d = wa_data;
        b = rsv_eff && (rsv_addr == a);
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k]                  = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against
// an array-based model; a 2-port bypass build and a 4-port no-bypass build.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr2;
  logic [63:0] rd_data2;
  logic [1:0]  rd_busy2;
  logic [5:0]  cnt2;
  logic [19:0] rd_addr4;
  logic [127:0] rd_data4;
  logic [3:0]  rd_busy4;
  logic [5:0]  cnt4;
  logic        wa_en, wb_en, rsv_en;
  logic [4:0]  wa_addr, wb_addr, rsv_addr;
  logic [31:0] wa_data, wb_data;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0] mreg  [32];
  bit          mbusy [32];

  always #5 clk = ~clk;

  regfile_mp #(.NUM_RD(2), .BYPASS(1)) u2 (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(cnt2)
  );

  regfile_mp #(.NUM_RD(4), .BYPASS(0)) u4 (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_busy(rd_busy4),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(cnt4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic int model_cnt();
    int n = 0;
    foreach (mbusy[i]) n += int'(mbusy[i]);
    return n;
  endfunction

  // {busy, data} a read port should show this cycle
  function automatic logic [32:0] predict(input logic [4:0] a,
                                          input bit byp);
    bit rhit;
    rhit = rsv_en && (rsv_addr == a);
    if (a == 5'd0) return 33'd0;
    if (byp && !rst) begin
      if (wb_en && wb_addr == a) return {rhit, wb_data};
      if (wa_en && wa_addr == a) return {rhit, wa_data};
    end
    return {mbusy[a], mreg[a]};
  endfunction

  task automatic check_all();
    logic [32:0] e;
    logic [4:0]  a;
    #1;
    for (int k = 0; k < 2; k++) begin
      a = rd_addr2[k*5 +: 5];
      e = predict(a, 1'b1);
      chk($sformatf("u2.data[%0d]@r%0d", k, a),
          64'(rd_data2[k*32 +: 32]), 64'(e[31:0]));
      chk($sformatf("u2.busy[%0d]@r%0d", k, a),
          64'(rd_busy2[k]), 64'(e[32]));
    end
    for (int k = 0; k < 4; k++) begin
      a = rd_addr4[k*5 +: 5];
      e = predict(a, 1'b0);
      chk($sformatf("u4.data[%0d]@r%0d", k, a),
          64'(rd_data4[k*32 +: 32]), 64'(e[31:0]));
      chk($sformatf("u4.busy[%0d]@r%0d", k, a),
          64'(rd_busy4[k]), 64'(e[32]));
    end
    chk("u2.busy_cnt", 64'(cnt2), 64'(model_cnt()));
    chk("u4.busy_cnt", 64'(cnt4), 64'(model_cnt()));
  endtask

  task automatic model_edge();
    if (rst) begin
      foreach (mreg[i]) begin
        mreg[i]  = '0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (wa_en && wa_addr != 0) begin
        mreg[wa_addr]  = wa_data;
        mbusy[wa_addr] = 1'b0;
      end
      if (wb_en && wb_addr != 0) begin
        mreg[wb_addr]  = wb_data;
        mbusy[wb_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0)
        mbusy[rsv_addr] = 1'b1;
    end
  endtask

  // inputs are set just after negedge; check, clock, advance model
  task automatic cycle();
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0;
    wa_en = 0; wb_en = 0; rsv_en = 0;
  endtask

  initial begin
    rst = 1;
    wa_en = 0; wb_en = 0; rsv_en = 0;
    wa_addr = 0; wb_addr = 0; rsv_addr = 0;
    wa_data = 0; wb_data = 0;
    rd_addr2 = 0; rd_addr4 = 0;
    foreach (mreg[i]) begin
      mreg[i]  = 'x;
      mbusy[i] = 1'b0;
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);

    // reset state on every address and port
    idle();
    for (int a = 0; a < 32; a++) begin
      rd_addr2 = {5'(31 - a), 5'(a)};
      rd_addr4 = {5'(a), 5'(31 - a), 5'(a ^ 1), 5'(a)};
      cycle();
    end

    // reserve r5 then write it through port A
    rd_addr2 = {5'd0, 5'd5};
    rd_addr4 = {15'd0, 5'd5};
    rsv_en = 1; rsv_addr = 5;
    cycle();
    idle();
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
    #1;
    chk("cnt_after_rsv", 64'(cnt2), 64'd1);
    chk("byp_dead_data", 64'(rd_data2[31:0]), 64'hDEADBEEF);
    chk("byp_dead_busy", 64'(rd_busy2[0]), 64'd0);
    chk("nobyp_dead_busy", 64'(rd_busy4[0]), 64'd1);
    cycle();
    idle();
    #1;
    chk("cnt_after_wr", 64'(cnt2), 64'd0);
    chk("nobyp_dead_data", 64'(rd_data4[31:0]), 64'hDEADBEEF);
    cycle();

    // both ports to r7, plus r0 write dropped
    rd_addr2 = {5'd0, 5'd7};
    rd_addr4 = {10'd0, 5'd0, 5'd7};
    wa_en = 1; wa_addr = 7; wa_data = 32'h11111111;
    wb_en = 1; wb_addr = 7; wb_data = 32'h22222222;
    #1;
    chk("r7_byp_b_wins", 64'(rd_data2[31:0]), 64'h22222222);
    cycle();
    idle();
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
    cycle();
    idle();
    #1;
    chk("r7_stored", 64'(rd_data4[31:0]), 64'h22222222);
    chk("r0_zero", 64'(rd_data4[63:32]), 64'd0);
    cycle();

    // reserve and write r9 together, then double reserve
    rd_addr2 = {5'd0, 5'd9};
    rd_addr4 = {15'd0, 5'd9};
    rsv_en = 1; rsv_addr = 9;
    wb_en = 1; wb_addr = 9; wb_data = 32'h5;
    #1;
    chk("r9_byp_busy", 64'(rd_busy2[0]), 64'd1);
    cycle();
    idle();
    #1;
    chk("r9_cnt", 64'(cnt2), 64'd1);
    chk("r9_data", 64'(rd_data4[31:0]), 64'd5);
    rsv_en = 1; rsv_addr = 9;
    cycle();
    idle();
    #1;
    chk("r9_dbl_rsv_cnt", 64'(cnt2), 64'd1);
    cycle();

    // fill the scoreboard, then reset with a colliding write
    for (int a = 1; a < 32; a++) begin
      rsv_en = 1; rsv_addr = 5'(a);
      cycle();
    end
    idle();
    rd_addr2 = {5'd0, 5'd3};
    rd_addr4 = {15'd0, 5'd3};
    #1;
    chk("full_cnt", 64'(cnt2), 64'd31);
    rst = 1;
    wa_en = 1; wa_addr = 3; wa_data = 32'hCAFEF00D;
    cycle();
    idle();
    #1;
    chk("rst_cnt", 64'(cnt2), 64'd0);
    chk("rst_r3", 64'(rd_data2[31:0]), 64'd0);
    chk("rst_r3_busy", 64'(rd_busy2[0]), 64'd0);
    cycle();

    // four-port simultaneous read
    wa_en = 1; wa_addr = 1; wa_data = 32'hA;
    wb_en = 1; wb_addr = 2; wb_data = 32'hB;
    cycle();
    idle();
    rd_addr4 = {5'd0, 5'd1, 5'd2, 5'd1};
    #1;
    chk("p4_r1", 64'(rd_data4[31:0]), 64'hA);
    chk("p4_r2", 64'(rd_data4[63:32]), 64'hB);
    chk("p4_r1b", 64'(rd_data4[95:64]), 64'hA);
    chk("p4_r0", 64'(rd_data4[127:96]), 64'h0);
    cycle();

    // random traffic with deliberate address collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] m;
      m = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
      rst      = ($urandom_range(0, 60) == 0);
      wa_en    = 1'($urandom);
      wb_en    = 1'($urandom);
      rsv_en   = 1'($urandom);
      wa_addr  = 5'($urandom) & m;
      wb_addr  = 5'($urandom) & m;
      rsv_addr = 5'($urandom) & m;
      wa_data  = $urandom;
      wb_data  = $urandom;
      rd_addr2 = {5'($urandom) & m, 5'($urandom) & m};
      rd_addr4 = {5'($urandom) & m, 5'($urandom) & m,
                  5'($urandom) & m, 5'($urandom) & m};
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
